// File: rtl/snake_display_pkg.sv
// Shared constants and types for the on-screen digit fields (score, time).
//   DIGIT_CELLS  glyph edge length in ROM cells (glyphs are square)
//   GLYPH_BITS   bits per glyph in the numbers ROM (row*10+col indexing)
//   BLANK_GLYPH  ROM glyph select that renders nothing
//   VALUE_W      width of the binary value being displayed
//   BCD_DIGITS   digits produced by the BCD converter (display uses the low NUM_DIGITS)
package snake_display_pkg;
  localparam int DIGIT_CELLS = 10;
  localparam int GLYPH_BITS  = 100;
  localparam logic [3:0] BLANK_GLYPH = 4'd10;
  localparam int VALUE_W    = 14;
  localparam int BCD_DIGITS = 4;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
endpackage

// File: rtl/score_digit_ctrl_if.sv
// Bus between the digit sequencer and the numbers glyph ROM.
//   selected_number  glyph select (0-9, BLANK_GLYPH = empty); the ROM registers it
//   number_count     bit index row*10+col; the ROM uses it combinationally
//   number_pixel     glyph bit returned by the ROM
// master = sequencer, slave = ROM.
interface score_digit_ctrl_if;
  logic [3:0] selected_number;
  logic [7:0] number_count;
  logic       number_pixel;

  modport master (output selected_number, output number_count, input number_pixel);
  modport slave  (input selected_number, input number_count, output number_pixel);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter, one bit per cycle.
//   start   load value and begin converting (ignored stream is restarted)
//   value   binary input, VALUE_W bits
//   busy    high for the VALUE_W shift cycles
//   done    high during the final shift cycle; bcd is valid from the next cycle
//   bcd     BCD_DIGITS packed digits, units in the low nibble (held until next start)
module bin2bcd_seq
  import snake_display_pkg::*;
(
  input  logic                  clock_25,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [VALUE_W-1:0]    value,
  output logic                  busy,
  output logic                  done,
  output logic [4*BCD_DIGITS-1:0] bcd
);
  localparam int SR_W = 4*BCD_DIGITS + VALUE_W;

  logic [SR_W-1:0] sr, sr_adj;
  logic [4:0]      cnt;

  // Add 3 to every BCD nibble >= 5 so the following shift carries correctly.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (sr[VALUE_W+4*i +: 4] >= 4'd5)
        sr_adj[VALUE_W+4*i +: 4] = sr[VALUE_W+4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clock_25 or negedge resetn) begin
    if (!resetn) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      sr   <= {{(4*BCD_DIGITS){1'b0}}, value};
      cnt  <= 5'(VALUE_W);
      busy <= 1'b1;
    end else if (busy) begin
      sr  <= {sr_adj[SR_W-2:0], 1'b0};
      cnt <= cnt - 5'd1;
      if (cnt == 5'd1) busy <= 1'b0;
    end
  end

  assign done = busy && (cnt == 5'd1);
  assign bcd  = sr[SR_W-1 -: 4*BCD_DIGITS];
endmodule

// File: rtl/score_digit_ctrl.sv
// Draws a NUM_DIGITS decimal field from the numbers glyph ROM.
// A binary value is captured, converted to BCD at the next vblank and committed
// to the display register in one cycle. Each raster pixel is mapped to a digit,
// glyph row and column; the ROM select is issued one cycle ahead of its bit
// index, and the returned glyph bit comes back as digit_pixel_on 3 cycles after
// the pixel coordinates.
//   clock_25, resetn            pixel clock, async active-low reset
//   pixel_x, pixel_y            raster position
//   frame_start                 vblank pulse; starts a pending conversion
//   value_load, value_in        capture strobe and binary value (saturated)
//   rom                         numbers ROM bus (master side)
//   digit_pixel_on              foreground flag for the pixel of 3 cycles ago
//   busy                        conversion/commit in progress
module score_digit_ctrl
  import snake_display_pkg::*;
#(
  parameter int X0         = 100,
  parameter int Y0         = 20,
  parameter int SCALE      = 2,
  parameter int GAP        = 4,
  parameter int NUM_DIGITS = 4,
  parameter int LEAD_BLANK = 1
) (
  input  logic                clock_25,
  input  logic                resetn,
  input  logic [9:0]          pixel_x,
  input  logic [9:0]          pixel_y,
  input  logic                frame_start,
  input  logic                value_load,
  input  logic [VALUE_W-1:0]  value_in,
  score_digit_ctrl_if.master  rom,
  output logic                digit_pixel_on,
  output logic                busy
);
  localparam int GLYPH_W = DIGIT_CELLS * SCALE;
  localparam int PITCH   = GLYPH_W + GAP;
  localparam int FIELD_W = NUM_DIGITS * PITCH - GAP;
  localparam logic [VALUE_W-1:0] MAX_VAL = VALUE_W'(pow10(NUM_DIGITS) - 1);

  // ---------------- capture + conversion control ----------------
  conv_state_e state, state_nxt;
  logic                   pending;
  logic [VALUE_W-1:0]     capture, value_sat, conv_value;
  logic                   conv_start, conv_busy, conv_done;
  logic [4*BCD_DIGITS-1:0] conv_bcd;
  bcd_digit_t [BCD_DIGITS-1:0] disp_dig;  // units at index 0

  assign value_sat  = (value_in > MAX_VAL) ? MAX_VAL : value_in;
  // A load in the same cycle as frame_start is converted directly.
  assign conv_value = value_load ? value_sat : capture;

  always_comb begin
    state_nxt  = state;
    conv_start = 1'b0;
    case (state)
      ST_IDLE:
        if (frame_start && (pending || value_load)) begin
          state_nxt  = ST_CONV;
          conv_start = 1'b1;
        end
      ST_CONV:   if (conv_done) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_25 or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      pending  <= 1'b0;
      capture  <= '0;
      disp_dig <= '0;
    end else begin
      state <= state_nxt;
      if (value_load) capture <= value_sat;
      if (conv_start)      pending <= 1'b0;
      else if (value_load) pending <= 1'b1;
      if (state == ST_COMMIT) disp_dig <= conv_bcd;
    end
  end

  assign busy = (state != ST_IDLE);

  bin2bcd_seq u_bcd (
    .clock_25 (clock_25),
    .resetn   (resetn),
    .start    (conv_start),
    .value    (conv_value),
    .busy     (conv_busy),
    .done     (conv_done),
    .bcd      (conv_bcd)
  );

  // ---------------- raster stage 0 ----------------
  logic [9:0] dx, dy, off;
  logic [1:0] dig_k, dig_idx;
  logic [3:0] col, row;
  logic       in_x, in_y, in_gap, in_glyph;
  logic [7:0] cell_idx;
  logic [NUM_DIGITS-1:0] blank_k;  // MSD-first, like dig_k
  logic       zero_run;

  assign dx   = pixel_x - 10'(X0);
  assign dy   = pixel_y - 10'(Y0);
  assign in_x = ({1'b0, pixel_x} >= 11'(X0)) && ({1'b0, pixel_x} < 11'(X0 + FIELD_W));
  assign in_y = ({1'b0, pixel_y} >= 11'(Y0)) && ({1'b0, pixel_y} < 11'(Y0 + GLYPH_W));

  // Digit, column and row by comparing against constant multiples: cheap for
  // at most 4 digits and 10 cells, and works for any SCALE without a divider.
  always_comb begin
    dig_k = '0;
    off   = dx;
    for (int j = 1; j < NUM_DIGITS; j++)
      if (dx >= 10'(j * PITCH)) begin
        dig_k = 2'(j);
        off   = dx - 10'(j * PITCH);
      end
    col = '0;
    for (int c = 1; c < DIGIT_CELLS; c++)
      if (off >= 10'(c * SCALE)) col = 4'(c);
    row = '0;
    for (int r = 1; r < DIGIT_CELLS; r++)
      if (dy >= 10'(r * SCALE)) row = 4'(r);
  end

  assign in_gap   = (off >= 10'(GLYPH_W));
  assign in_glyph = in_x && in_y && !in_gap;
  assign dig_idx  = 2'(NUM_DIGITS - 1) - dig_k;
  assign cell_idx = 8'(row) * 8'd10 + 8'(col);

  // A digit is blank while it and every more significant digit are zero.
  always_comb begin
    zero_run = 1'b1;
    blank_k  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zero_run   = zero_run && (disp_dig[NUM_DIGITS-1-k] == 4'd0);
      blank_k[k] = (LEAD_BLANK != 0) && zero_run && (k != NUM_DIGITS - 1);
    end
  end

  // ---------------- ROM alignment pipeline ----------------
  // The ROM registers the glyph select but indexes combinationally, so the bit
  // index trails the select by one cycle. vld_pipe carries in_glyph alongside.
  logic [7:0] cell_q;
  logic [1:0] vld_pipe;

  always_ff @(posedge clock_25 or negedge resetn) begin
    if (!resetn) begin
      rom.selected_number <= '0;
      rom.number_count    <= '0;
      cell_q              <= '0;
      vld_pipe            <= '0;
      digit_pixel_on      <= 1'b0;
    end else begin
      rom.selected_number <= (in_glyph && !blank_k[dig_k]) ? disp_dig[dig_idx] : BLANK_GLYPH;
      cell_q              <= in_glyph ? cell_idx : 8'd0;
      rom.number_count    <= cell_q;
      vld_pipe            <= {vld_pipe[0], in_glyph};
      digit_pixel_on      <= rom.number_pixel & vld_pipe[1];
    end
  end
endmodule

// File: tb/tb_score_digit_ctrl.sv
// Directed bench for score_digit_ctrl with a segment-style numbers ROM model.
// Two instances share stimulus: leading-zero blanking on (a) and off (b).
module tb_score_digit_ctrl;
  logic        clock_25 = 1'b0;
  logic        resetn;
  logic [9:0]  pixel_x, pixel_y;
  logic        frame_start, value_load;
  logic [13:0] value_in;
  logic        on_a_w, on_b_w, busy_a, busy_b;

  score_digit_ctrl_if rom_a ();
  score_digit_ctrl_if rom_b ();

  always #20 clock_25 = ~clock_25;

  score_digit_ctrl u_dut_a (
    .clock_25(clock_25), .resetn(resetn), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .value_load(value_load), .value_in(value_in),
    .rom(rom_a), .digit_pixel_on(on_a_w), .busy(busy_a));

  score_digit_ctrl #(.LEAD_BLANK(0)) u_dut_b (
    .clock_25(clock_25), .resetn(resetn), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .value_load(value_load), .value_in(value_in),
    .rom(rom_b), .digit_pixel_on(on_b_w), .busy(busy_b));

  // Glyph ROM model: segments a..g on a 10x10 grid, glyph select registered.
  function automatic logic glyph_bit(input logic [3:0] g, input logic [7:0] idx);
    logic [6:0] seg;  // {a,b,c,d,e,f,g}
    int r, c;
    r = int'(idx) / 10;
    c = int'(idx) % 10;
    case (g)
      4'd0: seg = 7'b1111110;  4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;  4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;  4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;  4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;  4'd9: seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    if (idx > 8'd99) return 1'b0;
    return (seg[6] && r == 0) || (seg[5] && c == 9 && r <= 4) || (seg[4] && c == 9 && r >= 5) ||
           (seg[3] && r == 9) || (seg[2] && c == 0 && r >= 5) || (seg[1] && c == 0 && r <= 4) ||
           (seg[0] && r == 4);
  endfunction

  logic [3:0] glyph_q_a, glyph_q_b;
  always @(posedge clock_25) begin
    glyph_q_a <= rom_a.selected_number;
    glyph_q_b <= rom_b.selected_number;
  end
  assign rom_a.number_pixel = glyph_bit(glyph_q_a, rom_a.number_count);
  assign rom_b.number_pixel = glyph_bit(glyph_q_b, rom_b.number_count);

  int n_cmp = 0;
  int n_fail = 0;
  logic [3:0] sel_a, sel_b;
  logic [7:0] cnt_a;
  logic       on_a, on_b;
  int         busy_cycles;
  int         xh[0:31];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel, then off-field; collect each pipeline stage at its own cycle.
  task automatic probe(input int x, input int y);
    @(negedge clock_25); pixel_x = 10'(x); pixel_y = 10'(y);
    @(negedge clock_25); pixel_x = '0; pixel_y = '0;
    sel_a = rom_a.selected_number; sel_b = rom_b.selected_number;
    @(negedge clock_25); cnt_a = rom_a.number_count;
    @(negedge clock_25); on_a = on_a_w; on_b = on_b_w;
  endtask

  task automatic load(input int v, input logic with_frame);
    @(negedge clock_25); value_in = 14'(v); value_load = 1'b1; frame_start = with_frame;
    @(negedge clock_25); value_load = 1'b0; frame_start = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clock_25); frame_start = 1'b1;
    @(negedge clock_25); frame_start = 1'b0;
  endtask

  // Counts busy cycles until busy falls; bounded.
  task automatic wait_conv(output int cycles);
    cycles = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy_a) cycles++;
      else if (cycles > 0) break;
      @(negedge clock_25);
    end
  endtask

  initial begin
    resetn = 1'b0; pixel_x = '0; pixel_y = '0;
    frame_start = 1'b0; value_load = 1'b0; value_in = '0;
    repeat (3) @(negedge clock_25);
    check("rst_sel", 32'(rom_a.selected_number), 0);
    check("rst_cnt", 32'(rom_a.number_count), 0);
    check("rst_on", 32'(on_a_w), 0);
    check("rst_busy", 32'(busy_a), 0);
    resetn = 1'b1;

    // Row 0 sweep over digit 2 gap and units "0": on exactly for x 172..191, 3 cycles late.
    pixel_y = 10'd20;
    for (int i = 0; i < 32; i++) begin
      @(negedge clock_25);
      if (i >= 3) check("sweep_on", 32'(on_a_w), (xh[i-3] >= 172 && xh[i-3] <= 191) ? 1 : 0);
      xh[i] = 168 + i;
      pixel_x = 10'(xh[i]);
    end
    probe(100, 20);
    check("zero_lead_sel", 32'(sel_a), 10);
    check("zero_lead_on", 32'(on_a), 0);
    check("zero_nb_sel", 32'(sel_b), 0);
    check("zero_nb_on", 32'(on_b), 1);

    // 1234 via pending path
    load(1234, 1'b0);
    @(negedge clock_25);
    check("pend_idle", 32'(busy_a), 0);
    pulse_frame();
    wait_conv(busy_cycles);
    check("busy_len", 32'(busy_cycles), 15);
    probe(118, 20);
    check("d1_c9_sel", 32'(sel_a), 1);
    check("d1_c9_cnt", 32'(cnt_a), 9);
    check("d1_c9_on", 32'(on_a), 1);
    probe(100, 20);
    check("d1_c0_cnt", 32'(cnt_a), 0);
    check("d1_c0_on", 32'(on_a), 0);
    probe(173, 29);
    check("d4_sel", 32'(sel_a), 4);
    check("d4_cnt", 32'(cnt_a), 40);
    check("d4_on", 32'(on_a), 1);
    probe(121, 25);
    check("gap_sel", 32'(sel_a), 10);
    check("gap_cnt", 32'(cnt_a), 0);
    check("gap_on", 32'(on_a), 0);
    probe(99, 20);
    check("left_sel", 32'(sel_a), 10);
    check("left_on", 32'(on_a), 0);
    probe(192, 20);
    check("right_sel", 32'(sel_a), 10);
    check("right_on", 32'(on_a), 0);
    probe(191, 39);
    check("corner_cnt", 32'(cnt_a), 99);
    check("corner_on", 32'(on_a), 1);
    probe(150, 40);
    check("below_sel", 32'(sel_a), 10);
    check("below_cnt", 32'(cnt_a), 0);

    // 7: leading blank vs not
    load(7, 1'b0);
    pulse_frame();
    wait_conv(busy_cycles);
    probe(100, 20);
    check("b7_d0_sel", 32'(sel_a), 10);
    check("b7_d0_on", 32'(on_a), 0);
    check("nb7_d0_sel", 32'(sel_b), 0);
    check("nb7_d0_on", 32'(on_b), 1);
    probe(148, 20);
    check("b7_d2_sel", 32'(sel_a), 10);
    probe(190, 20);
    check("b7_u_sel", 32'(sel_a), 7);
    check("b7_u_on", 32'(on_a), 1);
    check("nb7_u_sel", 32'(sel_b), 7);

    // Saturation
    load(12000, 1'b0);
    pulse_frame();
    wait_conv(busy_cycles);
    probe(100, 20);
    check("sat_msd", 32'(sel_a), 9);
    probe(172, 20);
    check("sat_units", 32'(sel_a), 9);

    // 42 with load+frame in one cycle; 55 loaded and a frame pulse during CONV
    load(42, 1'b1);
    check("bypass_busy", 32'(busy_a), 1);
    @(negedge clock_25);
    load(55, 1'b0);
    pulse_frame();
    wait_conv(busy_cycles);
    check("conv42_end", 32'(busy_a), 0);
    probe(148, 20);
    check("v42_tens", 32'(sel_a), 4);
    probe(172, 20);
    check("v42_units", 32'(sel_a), 2);
    check("v42_wait", 32'(busy_a), 0);
    pulse_frame();
    wait_conv(busy_cycles);
    check("busy_len55", 32'(busy_cycles), 15);
    probe(148, 20);
    check("v55_tens", 32'(sel_a), 5);
    probe(172, 20);
    check("v55_units", 32'(sel_a), 5);
    probe(124, 20);
    check("v55_lead", 32'(sel_a), 10);
    pulse_frame();
    @(negedge clock_25);
    check("no_pend_busy", 32'(busy_a), 0);

    // Reset during conversion
    load(8888, 1'b1);
    repeat (4) @(negedge clock_25);
    check("mid_busy", 32'(busy_a), 1);
    resetn = 1'b0;
    @(negedge clock_25);
    check("abort_busy", 32'(busy_a), 0);
    resetn = 1'b1;
    probe(172, 20);
    check("abort_units", 32'(sel_a), 0);
    probe(148, 20);
    check("abort_lead", 32'(sel_a), 10);
    check("abort_nb", 32'(sel_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
